// File: rtl/snn_enc_pkg.sv
// Shared definitions for the spike encoder path: encoder state encoding and
// the period code constants common with the intensity-to-period mapper.
package snn_enc_pkg;

    localparam int PERIOD_W = 8;
    localparam logic [PERIOD_W-1:0] SILENT_PERIOD = 8'd255;
    localparam int MIN_PERIOD_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } enc_state_t;

endpackage

// File: rtl/spike_phase_counter.sv
// Per-train phase accumulator: counts enabled timesteps and fires when the
// phase reaches period-1, then wraps. Silent period holds phase at zero.
module spike_phase_counter
    import snn_enc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                fire_o,
    output logic [PERIOD_W-1:0] phase_o
);

    logic [PERIOD_W-1:0] phase_q;
    logic [PERIOD_W-1:0] phase_d;
    logic                silent;

    assign silent  = (period_i == SILENT_PERIOD);
    // period_i is never below 1 while running, so the 8-bit subtract cannot wrap
    assign fire_o  = en_i && !silent && (phase_q == period_i - 8'd1);
    assign phase_o = phase_q;

    always_comb begin
        phase_d = phase_q;
        if (clear_i) begin
            phase_d = '0;
        end else if (en_i) begin
            if (fire_o || silent) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/rate_spike_encoder.sv
// Rate-coded spike train generator: one presentation window per accepted
// start, spike rate set by the captured period, spike count reported at end.
//
// state | meaning
// IDLE  | waiting for start; last spike_count held
// LOAD  | one settling cycle after capture, step_en ignored
// RUN   | counting timesteps, emitting spikes on phase wrap
// DONE  | one-cycle done pulse, back to IDLE
module rate_spike_encoder
    import snn_enc_pkg::*;
#(
    parameter int WIN_LEN    = 350,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int CNT_W      = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                step_en,
    input  logic                abort,
    output logic                spike,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    spike_count
);

    localparam int STEP_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(WIN_LEN - 1);
    localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(MIN_PERIOD);

    enc_state_t          state_q;
    logic                spike_q;
    logic                busy_q;
    logic                done_q;
    logic [CNT_W-1:0]    count_q;
    logic [STEP_W-1:0]   step_q;
    logic [PERIOD_W-1:0] period_q;

    logic [PERIOD_W-1:0] period_eff;
    logic                phase_clear;
    logic                phase_en;
    logic                fire;
    logic [PERIOD_W-1:0] dbg_phase_unused;

    always_comb begin
        period_eff = period_in;
        if (period_in == SILENT_PERIOD) begin
            period_eff = SILENT_PERIOD;
        end else if (period_in < MIN_P) begin
            period_eff = MIN_P;
        end
    end

    assign phase_clear = (state_q == IDLE) && start;
    // abort wins over step_en, so the phase must not advance on an abort cycle
    assign phase_en    = (state_q == RUN) && step_en && !abort;

    spike_phase_counter u_phase (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (phase_clear),
        .en_i     (phase_en),
        .period_i (period_q),
        .fire_o   (fire),
        .phase_o  (dbg_phase_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            spike_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
            step_q   <= '0;
            period_q <= '0;
        end else begin
            spike_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        period_q <= period_eff;
                        count_q  <= '0;
                        step_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (step_en) begin
                        spike_q <= fire;
                        if (fire && (count_q != {CNT_W{1'b1}})) begin
                            count_q <= count_q + 1'b1;
                        end
                        step_q <= step_q + 1'b1;
                        if (step_q == LAST_STEP) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign spike       = spike_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign spike_count = count_q;

endmodule

// File: tb/tb_rate_spike_encoder.sv
// Scoreboard bench for rate_spike_encoder with a short window: the driver
// predicts spike cycles and window outcomes, a monitor checks what appears.
module tb_rate_spike_encoder;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] period_in = 8'd0;
    logic       step_en = 1'b0;
    logic       abort = 1'b0;
    logic       spike;
    logic       busy;
    logic       done;
    logic [8:0] spike_count;

    rate_spike_encoder #(.WIN_LEN(WIN), .MIN_PERIOD(2), .CNT_W(9)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .period_in   (period_in),
        .step_en     (step_en),
        .abort       (abort),
        .spike       (spike),
        .busy        (busy),
        .done        (done),
        .spike_count (spike_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int end_cyc;
        int cnt;
        int dn;
    } win_t;

    win_t win_q[$];
    int   spk_q[$];
    int   load_q[$];
    int   total = 0;
    int   bad = 0;
    bit   prev_busy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // effective period; 0 stands for the silent code
    function automatic int eff(input int p);
        if (p == 255) return 0;
        if (p < 2) return 2;
        return p;
    endfunction

    // monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if (spike) begin
                int want;
                want = (spk_q.size() > 0) ? spk_q[0] : -1;
                check("spike_cycle", cyc, want);
                if (want == cyc) void'(spk_q.pop_front());
            end
            if (busy && !prev_busy) begin
                int want;
                want = (load_q.size() > 0) ? load_q.pop_front() : -1;
                check("busy_rise_cycle", cyc, want);
            end
            if (!busy && prev_busy) begin
                if (win_q.size() == 0) begin
                    check("unexpected_window_end", cyc, -1);
                end else begin
                    win_t w;
                    int missed;
                    w = win_q.pop_front();
                    check("window_end_cycle", cyc, w.end_cyc);
                    check("done_at_end", int'(done), w.dn);
                    check("spike_count", int'(spike_count), w.cnt);
                    missed = 0;
                    while (spk_q.size() > 0 && spk_q[0] <= cyc) begin
                        missed++;
                        void'(spk_q.pop_front());
                    end
                    check("missed_spikes", missed, 0);
                end
            end else if (done) begin
                check("stray_done", cyc, -1);
            end
            prev_busy = busy;
        end
    end

    task automatic run_window(input int p, input int mode, input int abort_at,
                              input int reset_at, input bit early, input bit noise);
        int pe;
        int k;
        int j;
        bit en;
        win_t w;
        pe = eff(p);
        k = 0;
        j = 0;
        @(negedge clk);
        start = early; period_in = p[7:0]; step_en = 1'b0; abort = 1'b0;
        @(negedge clk);
        start = 1'b1; period_in = p[7:0];
        load_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0; step_en = 1'($urandom_range(0, 1)); period_in = 8'($urandom);
        while (k < WIN) begin
            @(negedge clk);
            if (mode == 0) en = 1'b1;
            else if (mode == 1) en = (j % 2 == 0);
            else en = 1'($urandom_range(0, 1));
            if (j > 80) en = 1'b1;
            j++;
            start = noise && ($urandom_range(0, 3) == 0);
            period_in = 8'($urandom_range(0, 3));
            if (k == abort_at) begin
                abort = 1'b1;
                step_en = 1'b1;
                w.end_cyc = cyc + 1;
                w.cnt = (pe == 0) ? 0 : k / pe;
                w.dn = 0;
                win_q.push_back(w);
                break;
            end
            if (k == reset_at) begin
                step_en = 1'b1;
                #2 rst = 1'b1;
                #1;
                check("rst_spike", int'(spike), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_count", int'(spike_count), 0);
                spk_q.delete();
                start = 1'b0; step_en = 1'b0;
                @(negedge clk);
                #1 rst = 1'b0;
                break;
            end
            step_en = en;
            if (en) begin
                if (pe != 0 && (k + 1) % pe == 0) spk_q.push_back(cyc + 1);
                k++;
                if (k == WIN) begin
                    w.end_cyc = cyc + 1;
                    w.cnt = (pe == 0) ? 0 : WIN / pe;
                    w.dn = 1;
                    win_q.push_back(w);
                end
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_spike", int'(spike), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_count", int'(spike_count), 0);

        run_window(4,   0, -1, -1, 1'b0, 1'b0);
        run_window(255, 0, -1, -1, 1'b0, 1'b0);
        run_window(1,   0, -1, -1, 1'b0, 1'b0);
        run_window(0,   0, -1, -1, 1'b0, 1'b0);
        run_window(3,   1, -1, -1, 1'b0, 1'b0);
        run_window(5,   0,  7, -1, 1'b0, 1'b0);
        run_window(2,   0, -1, -1, 1'b0, 1'b0);
        run_window(7,   0, -1, -1, 1'b0, 1'b1);
        run_window(2,   0, -1,  4, 1'b0, 1'b0);
        run_window(9,   0, -1, -1, 1'b0, 1'b0);
        run_window(10,  2, -1, -1, 1'b1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            int p;
            int ab;
            p  = ($urandom_range(0, 5) == 0) ? 255 : $urandom_range(0, 20);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, WIN - 1) : -1;
            run_window(p, $urandom_range(0, 2), ab, -1, 1'b0, 1'b1);
        end

        @(negedge clk);
        start = 1'b0; step_en = 1'b0; abort = 1'b0;
        repeat (6) @(negedge clk);
        check("pending_windows", win_q.size(), 0);
        check("pending_spikes", spk_q.size(), 0);
        check("pending_loads", load_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rate_spike_encoder.md
Name: rate_spike_encoder

Overview:
Stage directly downstream of the intensity-to-period reciprocal mapper. Takes its 8-bit inter-spike period, one value per input pixel, and drives a rate-coded spike train to the input neuron layer.
Each train lasts a fixed presentation window of WIN_LEN timesteps. A short period gives a high spike rate, and period 255 (the mapper's saturated "dark" code) gives silence.
On window completion the block reports the spike count and pulses done, so the sequencer can advance to the next pixel or image.

Parameters:
WIN_LEN, 350, timesteps per presentation window (must be >= 2)
MIN_PERIOD, 2, smallest legal period; smaller inputs are clamped up to this value
SILENT_PERIOD, 255, period code meaning "emit no spikes"
CNT_W, 9, width of spike_count; must hold WIN_LEN/MIN_PERIOD

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin a window; sampled only in IDLE
period_in  in  8  period from the mapper; captured on an accepted start
step_en  in  1  timestep tick; the window advances only on cycles where it is 1
abort  in  1  terminate the current window immediately; no done pulse
spike  out  1  registered one-cycle spike pulse
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle pulse when a window completes normally
spike_count  out  CNT_W  number of spikes in the last or current window; held until the next accepted start

Behaviour:
- Reset (async): state=IDLE; spike, busy, done = 0; spike_count, step_cnt, phase, period_reg = 0.
- State IDLE:
  - start=1 latches period_eff into period_reg, clears spike_count, step_cnt and phase, then goes to LOAD.
  - period_eff = SILENT_PERIOD if period_in==SILENT_PERIOD; MIN_PERIOD if period_in<MIN_PERIOD; otherwise period_in.
- State LOAD: one cycle, busy=1, no spike, then goes to RUN. LOAD ignores step_en.
- State RUN:
  - On each cycle with step_en=1:
    - If period_reg != SILENT_PERIOD and phase==period_reg-1: spike<=1, phase<=0, spike_count<=spike_count+1 (saturating at all-ones).
    - Otherwise: phase<=phase+1, spike<=0. In silent mode phase is held at 0.
    - step_cnt<=step_cnt+1. If step_cnt==WIN_LEN-1, go to DONE; a spike on this last step still counts.
  - On cycles with step_en=0: spike<=0; phase and step_cnt hold.
  - First spike occurs on step index period_reg-1 (0-based), giving floor(WIN_LEN/period) spikes per window.
- State DONE: done=1 and busy=0 for exactly one cycle, then back to IDLE.
- Latency: spike is registered and is asserted the cycle after the qualifying step_en cycle.
- Start handling: start during LOAD, RUN or DONE is ignored, with no queuing. A start in the same cycle as the DONE to IDLE transition is ignored; it is accepted the following cycle if still high.
- Abort:
  - abort in LOAD or RUN forces IDLE on the next edge: spike<=0, no done; spike_count keeps its partial value.
  - abort in IDLE has no effect. abort has priority over step_en in the same cycle.
- Reset mid-window: all state clears immediately; no done pulse.
- Widths: step_cnt is clog2(WIN_LEN) bits; phase is 8 bits. The compare period_reg-1 is computed in 8 bits, which is safe because period_reg >= MIN_PERIOD >= 1.

Decomposition:
- Shared package snn_enc_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE}
  - SILENT_PERIOD
  - the default MIN_PERIOD
  - the period width constant PERIOD_W=8, shared with the reciprocal mapper output
- Sub-module spike_phase_counter:
  - Inputs: clear, en, period.
  - Outputs: fire, and phase for debug.
  - The FSM and window counter stay in the top level.

Test Plan:
- WIN_LEN=16, period_in=4, step_en tied to 1, start pulse: spike after steps 3, 7, 11, 15; spike_count=4; done one cycle after the LOAD+16 RUN cycles; busy drops as done rises.
- period_in=255, WIN_LEN=16: no spikes, spike_count=0, done still pulses after 16 steps.
- period_in=1 and period_in=0, WIN_LEN=16: clamped to 2, so 8 spikes on odd steps and spike_count=8.
- period_in=3, step_en toggled 1,0,1,0…: spikes every 3rd enabled step only; window ends after 16 enabled steps (about 32 cycles); spike is never high on a step_en=0-derived cycle.
- period_in=5, WIN_LEN=16:
  - abort at step 7: goes to IDLE, spike_count=1, no done.
  - A new start with period 2 then gives 8 spikes.
- During RUN, pulse start with period_in=2: ignored, original period continues. Assert rst mid-RUN: outputs are 0 asynchronously, and the next start runs a clean window.
